// File: rtl/router_out_fifo.sv
// Per-port output buffer for the 1x3 router: show-ahead byte FIFO with header tagging,
// packet-boundary tracking and a self-flush when the destination reader stalls too long.
module router_out_fifo #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write_en,
  input  logic       lfd_state,
  input  logic [7:0] data_in,
  input  logic       read_en,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       hdr_out,
  output logic       last_out,
  output logic       full,
  output logic       empty,
  output logic       wr_drop,
  output logic       soft_rst
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [7:0]    STALL_LAST = 8'(TIMEOUT - 1);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  logic [6:0]    remaining_q, remaining_d;
  logic [7:0]    stallCnt_q, stallCnt_d;
  logic          wrDrop_q, wrDrop_d;
  logic          softRst_q, softRst_d;

  logic [8:0] headEntry;
  logic       stalled;
  logic       flush;
  logic       doPush;
  logic       doPop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_COUNT);
  assign valid_out = ~empty;
  assign headEntry = mem[rdPtr_q];
  assign data_out  = empty ? 8'h00 : headEntry[7:0];
  assign hdr_out   = ~empty & headEntry[8];
  assign last_out  = ~empty & ~headEntry[8] & (remaining_q == 7'd1);
  assign wr_drop   = wrDrop_q;
  assign soft_rst  = softRst_q;

  // Fullness is judged before the edge, so a same-cycle pop never makes room for a write.
  assign stalled = ~empty & ~read_en;
  assign flush   = stalled & (stallCnt_q == STALL_LAST);
  assign doPush  = write_en & ~full & ~flush;
  assign doPop   = read_en & ~empty;

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    stallCnt_d  = '0;
    wrDrop_d    = write_en & full & ~flush;
    softRst_d   = flush;

    if (flush) begin
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      count_d     = '0;
      remaining_d = '0;
    end else begin
      if (doPush) begin
        wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (doPop) begin
        rdPtr_d = rdPtr_q + PTR_ONE;
        // Header length field counts payload bytes; the parity byte adds one more.
        if (headEntry[8]) begin
          remaining_d = {1'b0, headEntry[7:2]} + 7'd1;
        end else if (remaining_q != 7'd0) begin
          remaining_d = remaining_q - 7'd1;
        end
      end
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (stalled) begin
        stallCnt_d = stallCnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      stallCnt_q  <= '0;
      wrDrop_q    <= 1'b0;
      softRst_q   <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      stallCnt_q  <= stallCnt_d;
      wrDrop_q    <= wrDrop_d;
      softRst_q   <= softRst_d;
    end
  end

  // Storage carries no reset; stale entries are never visible because outputs gate on empty.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr_q] <= {lfd_state, data_in};
    end
  end

endmodule
